axis_weighted_summer: RTL

AXIS_WEIGHTED_SUMMER -- requirements
Module: axis_weighted_summer

---
 rtl/axis_summer_pkg.sv | 24 ++
 rtl/axis_summer_lane.sv | 76 +++++++
 rtl/axis_weighted_summer.sv | 92 +++++++++
 3 files changed

// File: rtl/axis_summer_pkg.sv
// rtl/axis_summer_pkg.sv - shared constants and width helpers for the weighted summer
// Defaults, accumulator sizing and Q1.(WEIGHT_W-1) rounding helpers.
package axis_summer_pkg;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_SAMPLES  = 16;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_WEIGHT_W = 16;
  localparam int DEF_OUT_W    = 16;

  function automatic int acc_width(input int sample_w, input int weight_w, input int n_ch);
    return sample_w + weight_w + $clog2(n_ch);
  endfunction

  // Products carry WEIGHT_W-1 fractional bits; the half-LSB bias sits one bit below.
  function automatic int round_shift(input int weight_w);
    return weight_w - 1;
  endfunction

  function automatic int round_bias_bit(input int weight_w);
    return weight_w - 2;
  endfunction

endpackage

// File: rtl/axis_summer_lane.sv
// rtl/axis_summer_lane.sv - one sample position: multiply, channel sum, round, saturate
// Three register stages; stage 1 loads on ld, stages 2 and 3 advance with en.
module axis_summer_lane
  import axis_summer_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     ld,
  input  logic                     en,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic [N_CH*WEIGHT_W-1:0] weights,
  input  logic [N_CH*SAMPLE_W-1:0] samples,
  output logic [OUT_W-1:0]         out_q,
  output logic                     sat_d
);

  localparam int PROD_W = SAMPLE_W + WEIGHT_W;
  localparam int ACC_W  = acc_width(SAMPLE_W, WEIGHT_W, N_CH);
  localparam int SHIFT  = round_shift(WEIGHT_W);
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) << round_bias_bit(WEIGHT_W);

  logic signed [PROD_W-1:0] prod_d [N_CH];
  logic signed [PROD_W-1:0] prod_q [N_CH];
  logic signed [ACC_W-1:0]  sum_d, sum_q, rnd;
  logic [ACC_W-OUT_W:0]     top_bits;
  logic [OUT_W-1:0]         out_d;

  function automatic logic signed [PROD_W-1:0] mul(input logic [SAMPLE_W-1:0] s,
                                                   input logic [WEIGHT_W-1:0] w);
    logic signed [PROD_W-1:0] a, b;
    a = {{WEIGHT_W{s[SAMPLE_W-1]}}, s};
    b = {{SAMPLE_W{w[WEIGHT_W-1]}}, w};
    return a * b;
  endfunction

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      prod_d[c] = prod_q[c];
      if (ld) begin
        prod_d[c] = ch_enable[c] ? mul(samples[c*SAMPLE_W +: SAMPLE_W],
                                       weights[c*WEIGHT_W +: WEIGHT_W]) : '0;
      end
      sum_d = sum_d + {{(ACC_W-PROD_W){prod_q[c][PROD_W-1]}}, prod_q[c]};
    end
    rnd      = (sum_q + ROUND) >>> SHIFT;
    // Fits in OUT_W only when every bit above the output sign agrees with it.
    top_bits = rnd[ACC_W-1:OUT_W-1];
    sat_d    = ~((&top_bits) | ~(|top_bits));
    if (sat_d) begin
      out_d = rnd[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      out_d = rnd[OUT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int c = 0; c < N_CH; c++) prod_q[c] <= '0;
      sum_q <= '0;
      out_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) prod_q[c] <= prod_d[c];
      if (en) begin
        sum_q <= sum_d;
        out_q <= out_d;
      end
    end
  end

endmodule

// File: rtl/axis_weighted_summer.sv
// rtl/axis_weighted_summer.sv - joins N_CH streams and emits per-sample weighted sums
// Handshake, tlast tracking and counters; arithmetic lives in axis_summer_lane.
module axis_weighted_summer
  import axis_summer_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int SAMPLES  = DEF_SAMPLES,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [N_CH-1:0]                   ch_enable,
  input  logic [N_CH*WEIGHT_W-1:0]          weights,
  input  logic [N_CH*SAMPLES*SAMPLE_W-1:0]  s_axis_tdata,
  input  logic [N_CH-1:0]                   s_axis_tvalid,
  input  logic [N_CH-1:0]                   s_axis_tlast,
  output logic [N_CH-1:0]                   s_axis_tready,
  output logic [SAMPLES*OUT_W-1:0]          m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       sat_count,
  output logic                              last_mismatch
);

  logic en, join_ok, fire, last_or, last_and, sat_any;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic l1_d, l1_q, l2_d, l2_q, l3_d, l3_q;
  logic mismatch_d, mismatch_q;
  logic [31:0] sat_count_d, sat_count_q;
  logic [SAMPLES-1:0] lane_sat;
  logic [N_CH*SAMPLE_W-1:0] lane_in [SAMPLES];

  always_comb begin
    en       = ~v3_q | m_axis_tready;
    join_ok  = &(s_axis_tvalid | ~ch_enable);
    fire     = en & join_ok & (|ch_enable);
    last_or  = |(s_axis_tlast & ch_enable);
    last_and = &(s_axis_tlast | ~ch_enable);
    sat_any  = |lane_sat;
    for (int c = 0; c < N_CH; c++) begin
      s_axis_tready[c] = resetn & en & (join_ok | ~ch_enable[c]);
    end
    for (int i = 0; i < SAMPLES; i++) begin
      lane_in[i] = '0;
      for (int c = 0; c < N_CH; c++) begin
        lane_in[i][c*SAMPLE_W +: SAMPLE_W] = s_axis_tdata[(c*SAMPLES+i)*SAMPLE_W +: SAMPLE_W];
      end
    end
    v1_d = en ? fire : v1_q;
    v2_d = en ? v1_q : v2_q;
    v3_d = en ? v2_q : v3_q;
    l1_d = fire ? last_or : l1_q;
    l2_d = en ? l1_q : l2_q;
    l3_d = en ? l2_q : l3_q;
    mismatch_d  = mismatch_q | (fire & last_or & ~last_and);
    sat_count_d = sat_count_q;
    if (en & v2_q & sat_any & ~(&sat_count_q)) sat_count_d = sat_count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      {v1_q, v2_q, v3_q} <= '0;
      {l1_q, l2_q, l3_q} <= '0;
      mismatch_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      {v1_q, v2_q, v3_q} <= {v1_d, v2_d, v3_d};
      {l1_q, l2_q, l3_q} <= {l1_d, l2_d, l3_d};
      mismatch_q  <= mismatch_d;
      sat_count_q <= sat_count_d;
    end
  end

  for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
    axis_summer_lane #(
      .N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .WEIGHT_W(WEIGHT_W), .OUT_W(OUT_W)
    ) u_lane (
      .clock(clock), .resetn(resetn), .ld(fire), .en(en),
      .ch_enable(ch_enable), .weights(weights), .samples(lane_in[i]),
      .out_q(m_axis_tdata[i*OUT_W +: OUT_W]), .sat_d(lane_sat[i])
    );
  end

  assign m_axis_tvalid = v3_q;
  assign m_axis_tlast  = l3_q;
  assign sat_count     = sat_count_q;
  assign last_mismatch = mismatch_q;

endmodule
